// File: rtl/reg_file_resp_if.sv
// Register-bus between the cpu initiator and the register-file responder.
interface reg_file_resp_if #(
  parameter int BUSW  = 32,
  parameter int RINDW = 4
);
  logic             mutexLow;
  logic             rrwen;
  logic [RINDW-1:0] RegInd;
  logic [BUSW-1:0]  RegDbusOut;
  logic [BUSW-1:0]  RegDbusIn;
  logic             RegAck;
  logic             RegErr;
  logic             busy;

  modport master (
    output mutexLow, rrwen, RegInd, RegDbusOut,
    input  RegDbusIn, RegAck, RegErr, busy
  );

  modport slave (
    input  mutexLow, rrwen, RegInd, RegDbusOut,
    output RegDbusIn, RegAck, RegErr, busy
  );
endinterface

// File: rtl/reg_file_resp.sv
// Register-file responder: one read or write per bus claim, acknowledged
// with a single-cycle RegAck; register 0 is hardwired to zero.
module reg_file_resp #(
  parameter int       BUSW  = 32,
  parameter int       RINDW = 4,
  parameter int       NREGS = 16,
  parameter logic     REN   = 1'b1,
  parameter logic     WEN   = 1'b0
) (
  input logic             clk,
  input logic             rst,
  reg_file_resp_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, HOLD} state_t;

  localparam logic [RINDW:0] NREGS_W = (RINDW + 1)'(NREGS);

  state_t           state;
  state_t           state_nx;
  logic [RINDW-1:0] idx_q;
  logic [BUSW-1:0]  wdata_q;
  logic [BUSW-1:0]  regs [NREGS];
  logic             in_range;
  logic             access;

  assign in_range = ({1'b0, idx_q} < NREGS_W);
  assign access   = (state == READ) || (state == WRITE);
  assign bus.busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (!bus.mutexLow) begin
          // An unknown rrwen falls to the else branch, i.e. a write.
          if (bus.rrwen == REN) state_nx = READ;
          else                  state_nx = WRITE;
        end
      end
      READ:    state_nx = HOLD;
      WRITE:   state_nx = HOLD;
      HOLD:    if (bus.mutexLow) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Request fields are captured on the claim edge; later bus changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q         <= '0;
      wdata_q       <= '0;
      bus.RegDbusIn <= '0;
      bus.RegAck    <= 1'b0;
      bus.RegErr    <= 1'b0;
    end else begin
      if (state == IDLE && !bus.mutexLow) begin
        idx_q   <= bus.RegInd;
        wdata_q <= bus.RegDbusOut;
      end
      bus.RegAck <= access;
      bus.RegErr <= access && !in_range;
      if (state == READ)
        bus.RegDbusIn <= in_range ? regs[idx_q] : '0;
    end
  end

  // NOTE: the register array is explicitly cleared on reset because software
  // relies on every register reading zero after reset; this costs a reset
  // net per flop and rules out mapping the array onto RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == WRITE && in_range && idx_q != '0) begin
      regs[idx_q] <= wdata_q;
    end
  end

  logic unused_wen;
  assign unused_wen = WEN;

endmodule

// File: tb/tb_reg_file_resp.sv
// Directed self-checking bench for reg_file_resp built with NREGS=12 so
// out-of-range indices can be exercised.
module tb_reg_file_resp;

  localparam int   BUSW  = 32;
  localparam int   RINDW = 4;
  localparam int   NREGS = 12;
  localparam logic REN   = 1'b1;
  localparam logic WEN   = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  reg_file_resp_if #(.BUSW(BUSW), .RINDW(RINDW)) bus ();

  reg_file_resp #(
    .BUSW(BUSW), .RINDW(RINDW), .NREGS(NREGS), .REN(REN), .WEN(WEN)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Claim at a negedge, scramble inputs after the claim edge, check the ack
  // two edges later, release, and confirm return to IDLE.
  task automatic access(input string tag, input logic rw, input logic [3:0] idx,
                        input logic [31:0] data, input logic early,
                        input logic [31:0] exp_rd, input logic exp_err);
    bus.mutexLow   = 1'b0;
    bus.rrwen      = rw;
    bus.RegInd     = idx;
    bus.RegDbusOut = data;
    @(negedge clk);
    check({tag, "_busy1"}, bus.busy, 1);
    check({tag, "_ack_early"}, bus.RegAck, 0);
    bus.RegInd     = ~idx;
    bus.RegDbusOut = ~data;
    bus.rrwen      = ~rw;
    if (early) bus.mutexLow = 1'b1;
    @(negedge clk);
    check({tag, "_ack"}, bus.RegAck, 1);
    check({tag, "_err"}, bus.RegErr, exp_err);
    check({tag, "_rdata"}, bus.RegDbusIn, exp_rd);
    bus.mutexLow = 1'b1;
    @(negedge clk);
    check({tag, "_ack_clr"}, bus.RegAck, 0);
    check({tag, "_idle"}, bus.busy, 0);
  endtask

  initial begin
    bus.mutexLow   = 1'b1;
    bus.rrwen      = REN;
    bus.RegInd     = '0;
    bus.RegDbusOut = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_ack", bus.RegAck, 0);
    check("rst_err", bus.RegErr, 0);
    check("rst_rdata", bus.RegDbusIn, 0);
    rst = 1'b0;
    @(negedge clk);

    // Write then read r3; rdata must persist across the write.
    access("wr_r3", WEN, 4'd3, 32'hA5A5_0001, 1'b0, 32'h0, 1'b0);
    access("rd_r3", REN, 4'd3, 32'h0, 1'b0, 32'hA5A5_0001, 1'b0);

    // Reset asserted in WRITE of r5 aborts it and clears everything.
    bus.mutexLow   = 1'b0;
    bus.rrwen      = WEN;
    bus.RegInd     = 4'd5;
    bus.RegDbusOut = 32'hDEAD;
    @(negedge clk);
    check("mid_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_rdata", bus.RegDbusIn, 0);
    check("mid_rst_ack", bus.RegAck, 0);
    bus.mutexLow = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    access("rd_r5_after_rst", REN, 4'd5, 32'h0, 1'b0, 32'h0, 1'b0);
    access("rd_r3_after_rst", REN, 4'd3, 32'h0, 1'b0, 32'h0, 1'b0);

    // Register 0 is hardwired to zero, no error.
    access("wr_r0", WEN, 4'd0, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    access("rd_r0", REN, 4'd0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Out-of-range index 13 with NREGS=12; r1 must not be aliased.
    access("wr_r1", WEN, 4'd1, 32'h0101_0101, 1'b0, 32'h0, 1'b0);
    access("wr_r13", WEN, 4'd13, 32'h0000_0BAD, 1'b0, 32'h0, 1'b1);
    access("rd_r1", REN, 4'd1, 32'h0, 1'b0, 32'h0101_0101, 1'b0);
    access("wr_r11", WEN, 4'd11, 32'h1111_0011, 1'b0, 32'h0101_0101, 1'b0);
    access("rd_r13", REN, 4'd13, 32'h0, 1'b0, 32'h0, 1'b1);
    access("rd_r11", REN, 4'd11, 32'h0, 1'b0, 32'h1111_0011, 1'b0);

    // Claim held 10 cycles past the ack: single ack, busy throughout.
    bus.mutexLow = 1'b0;
    bus.rrwen    = REN;
    bus.RegInd   = 4'd1;
    repeat (2) @(negedge clk);
    check("hold_ack", bus.RegAck, 1);
    check("hold_rdata", bus.RegDbusIn, 32'h0101_0101);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("hold_ack0_%0d", i), bus.RegAck, 0);
      check($sformatf("hold_busy_%0d", i), bus.busy, 1);
    end
    bus.mutexLow = 1'b1;
    @(negedge clk);
    check("hold_release_idle", bus.busy, 0);
    access("hold_next_claim", REN, 4'd11, 32'h0, 1'b0, 32'h1111_0011, 1'b0);

    // Early release during WRITE of r7.
    access("wr_r7_early", WEN, 4'd7, 32'h0000_1234, 1'b1, 32'h1111_0011, 1'b0);
    access("rd_r7", REN, 4'd7, 32'h0, 1'b0, 32'h0000_1234, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
